id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage for the 64-bit pipelined ARM core.
- Consumes the two combinational read ports of the register file and resolves data hazards. It forwards results from the EX, MEM and WB stages, and detects load-use hazards by stalling IF/ID and inserting a bubble.
- Registers the resolved operands and control into the ID/EX pipeline register.
- Also keeps a saturating stall counter for performance monitoring.

Parameters:
- CTRL_W, 16, width of opaque EX/MEM/WB control bundle passed through unchanged
- CNT_W, 16, width of stall counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- id_valid  input  1  IF/ID holds a valid instruction
- id_rn  input  5  first source register (also drives register file ReadRegister1)
- id_rm  input  5  second source register (also drives ReadRegister2)
- id_uses_rn  input  1  instruction reads rn
- id_uses_rm  input  1  instruction reads rm
- id_rd  input  5  destination register
- id_reg_write  input  1  instruction writes rd
- id_is_load  input  1  instruction is LDUR
- id_imm  input  64  sign-extended immediate
- id_ctrl  input  CTRL_W  downstream control bundle
- rf_data1  input  64  register file ReadData1
- rf_data2  input  64  register file ReadData2
- ex_alu_result  input  64  combinational ALU output of instruction now in EX
- mem_reg_write  input  1  MEM-stage instruction writes a register
- mem_rd  input  5  MEM-stage destination
- mem_data  input  64  MEM-stage final value (load data or ALU result)
- wb_reg_write  input  1  WB write enable (same as register file RegWrite)
- wb_rd  input  5  WB destination (same as WriteRegister)
- wb_data  input  64  WB data (same as WriteData)
- flush  input  1  branch taken; squash the instruction in ID
- stall  output  1  combinational; hold PC and IF/ID this cycle
- ex_valid  output  1  ID/EX valid
- ex_op_a  output  64  resolved rn operand
- ex_op_b  output  64  resolved rm operand
- ex_imm  output  64  registered immediate
- ex_rd  output  5  registered destination
- ex_reg_write  output  1  registered write enable, qualified by valid
- ex_is_load  output  1  registered load flag, qualified by valid
- ex_ctrl  output  CTRL_W  registered control bundle
- stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: when reset_n=0 at the clock edge, all ID/EX outputs and stall_count are cleared to 0. stall is forced to 0 while reset_n=0.
- Latency: 1 cycle from ID inputs to the ex_* outputs.
- Register 31 (XZR):
  - A source of 31 always resolves to 64'b0, never forwarded.
  - A destination of 31 never matches any source.
- Forward match for a source s against a writer (we, rd): uses_s & s!=31 & we & rd==s.
- Operand priority per source, highest first:
  - EX: match against (ex_valid & ex_reg_write & !ex_is_load, ex_rd), using ex_alu_result.
  - MEM: match against (mem_reg_write, mem_rd), using mem_data.
  - WB: match against (wb_reg_write, wb_rd), using wb_data.
  - Otherwise the register file value.
- WB bypass is mandatory: the register file write lands at the same edge, so it is not yet visible on the read port.
- Load-use hazard:
  - Condition: id_valid & ex_valid & ex_is_load & ex_rd!=31, and ex_rd matches a used source (rn with id_uses_rn, or rm with id_uses_rm).
  - Response: stall=1, and the next ID/EX is a bubble.
- Bubble: ex_valid=0, ex_reg_write=0, ex_is_load=0. Other fields are don't-care; the implementation drives 0.
- Next-state priority, highest first:
  1. flush=1: bubble; stall=0.
  2. Load-use: bubble; stall=1.
  3. id_valid=0: bubble.
  4. Otherwise: capture the resolved operands, id_imm, id_rd and id_ctrl. Set ex_valid=1, ex_reg_write=id_reg_write, ex_is_load=id_is_load.
- Stall after one cycle: the hazard clears automatically because the load moves to MEM, so the held instruction then forwards from MEM.
- stall_count:
  - Increments at each edge where stall=1.
  - Saturates at all-ones and never wraps.
  - Unaffected by flush cycles.
- Both sources equal and both matched: each operand is resolved independently with the same value.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with id_valid=1 -> ex_valid=0, ex_op_a=0, stall=0, stall_count=0.
- No hazard: X1=5, X2=7 in the register file, ADD X3,X1,X2 -> next cycle ex_op_a=5, ex_op_b=7, ex_rd=3, ex_valid=1.
- EX-over-MEM priority: ADD X1 in EX with result 0x10, MEM writes X1=0x20, WB writes X1=0x30; SUB X4,X1,X1 -> ex_op_a=ex_op_b=0x10.
- WB bypass and XZR: wb writes X9=0xABCD while the instruction reads X9 and X31; mem_rd=31 with mem_reg_write=1 -> ex_op_a=0xABCD, ex_op_b=0.
- Load-use: LDUR X5 in EX, then ADD X6,X5,X2 in ID -> stall=1 for exactly 1 cycle and ex_valid=0 for that cycle. Next cycle mem_data=0x55 gives ex_op_a=0x55 and stall_count=1.
- Flush beats stall, and saturation: load-use condition with flush=1 -> stall=0, bubble, count unchanged. Force 65540 stall cycles -> stall_count=0xFFFF.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves register operands through EX/MEM/WB forwarding,
// detects load-use hazards and registers the result into the ID/EX pipeline register.
module id_ex_operand_stage #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rn,
  input  logic [4:0]        id_rm,
  input  logic              id_uses_rn,
  input  logic              id_uses_rm,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [63:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [63:0]       rf_data1,
  input  logic [63:0]       rf_data2,
  input  logic [63:0]       ex_alu_result,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_rd,
  input  logic [63:0]       mem_data,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [63:0]       wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [63:0]       ex_op_a,
  output logic [63:0]       ex_op_b,
  output logic [63:0]       ex_imm,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned XLEN = 64;
  localparam logic [4:0]  XZR  = 5'd31;

  logic            ex_fwd_en;
  logic            load_use;
  logic            capture;
  logic [XLEN-1:0] op_a_c;
  logic [XLEN-1:0] op_b_c;

  function automatic logic hit(input logic uses, input logic [4:0] src,
                               input logic we, input logic [4:0] dst);
    return uses && (src != XZR) && we && (dst == src);
  endfunction

  // A load in EX has no result yet, so it never forwards from EX.
  assign ex_fwd_en = ex_valid & ex_reg_write & ~ex_is_load;

  always_comb begin
    op_a_c = rf_data1;
    if (id_rn == XZR)                                     op_a_c = '0;
    else if (hit(id_uses_rn, id_rn, ex_fwd_en, ex_rd))    op_a_c = ex_alu_result;
    else if (hit(id_uses_rn, id_rn, mem_reg_write, mem_rd)) op_a_c = mem_data;
    else if (hit(id_uses_rn, id_rn, wb_reg_write, wb_rd))   op_a_c = wb_data;
  end

  always_comb begin
    op_b_c = rf_data2;
    if (id_rm == XZR)                                     op_b_c = '0;
    else if (hit(id_uses_rm, id_rm, ex_fwd_en, ex_rd))    op_b_c = ex_alu_result;
    else if (hit(id_uses_rm, id_rm, mem_reg_write, mem_rd)) op_b_c = mem_data;
    else if (hit(id_uses_rm, id_rm, wb_reg_write, wb_rd))   op_b_c = wb_data;
  end

  // Load-use: the instruction in ID needs a value the EX-stage load has not fetched yet.
  assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != XZR) &
                    ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

  assign stall   = reset_n & ~flush & load_use;
  assign capture = ~flush & ~load_use & id_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_ctrl      <= '0;
      stall_count  <= '0;
    end else begin
      if (capture) begin
        ex_valid     <= 1'b1;
        ex_op_a      <= op_a_c;
        ex_op_b      <= op_b_c;
        ex_imm       <= id_imm;
        ex_rd        <= id_rd;
        ex_reg_write <= id_reg_write;
        ex_is_load   <= id_is_load;
        ex_ctrl      <= id_ctrl;
      end else begin
        ex_valid     <= 1'b0;
        ex_op_a      <= '0;
        ex_op_b      <= '0;
        ex_imm       <= '0;
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_is_load   <= 1'b0;
        ex_ctrl      <= '0;
      end
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table, randomized run against a
// reference model, and stall counter saturation on a narrow-counter instance.
module tb_id_ex_operand_stage;

  typedef struct {
    logic        vld;
    logic [4:0]  rn, rm;
    logic        urn, urm;
    logic [4:0]  rd;
    logic        rw, ld;
    logic [63:0] imm;
    logic [15:0] ctrl;
    logic [63:0] rf1, rf2, exres;
    logic        mrw;
    logic [4:0]  mrd;
    logic [63:0] mdata;
    logic        wrw;
    logic [4:0]  wrd;
    logic [63:0] wdata;
    logic        fl;
    logic        e_stall, e_v;
    logic [63:0] e_a, e_b;
    logic [4:0]  e_rd;
    logic [15:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, id_valid, id_uses_rn, id_uses_rm, id_reg_write, id_is_load;
  logic [4:0]  id_rn, id_rm, id_rd, mem_rd, wb_rd;
  logic [63:0] id_imm, rf_data1, rf_data2, ex_alu_result, mem_data, wb_data;
  logic [15:0] id_ctrl;
  logic        mem_reg_write, wb_reg_write, flush;
  logic        stall, ex_valid, ex_reg_write, ex_is_load;
  logic [63:0] ex_op_a, ex_op_b, ex_imm;
  logic [4:0]  ex_rd;
  logic [15:0] ex_ctrl, stall_count;

  id_ex_operand_stage dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_alu_result(ex_alu_result), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_data(mem_data), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_op_a(ex_op_a),
    .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  // Narrow-counter instance: fixed "LDUR X5,[X5]" in ID stalls every other cycle.
  logic        s_rst_n;
  logic        s_stall, s_valid, s_rw, s_ld;
  logic [63:0] s_a, s_b, s_imm;
  logic [4:0]  s_rd;
  logic [15:0] s_ctrl;
  logic [3:0]  s_cnt;

  id_ex_operand_stage #(.CTRL_W(16), .CNT_W(4)) u_sat (
    .clk(clk), .reset_n(s_rst_n), .id_valid(1'b1), .id_rn(5'd5), .id_rm(5'd0),
    .id_uses_rn(1'b1), .id_uses_rm(1'b0), .id_rd(5'd5), .id_reg_write(1'b1),
    .id_is_load(1'b1), .id_imm(64'd0), .id_ctrl(16'd0), .rf_data1(64'd0),
    .rf_data2(64'd0), .ex_alu_result(64'd0), .mem_reg_write(1'b0), .mem_rd(5'd0),
    .mem_data(64'd0), .wb_reg_write(1'b0), .wb_rd(5'd0), .wb_data(64'd0),
    .flush(1'b0), .stall(s_stall), .ex_valid(s_valid), .ex_op_a(s_a), .ex_op_b(s_b),
    .ex_imm(s_imm), .ex_rd(s_rd), .ex_reg_write(s_rw), .ex_is_load(s_ld),
    .ex_ctrl(s_ctrl), .stall_count(s_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t ins(input logic vld, input logic [4:0] rn, input logic [4:0] rm,
                               input logic urn, input logic urm, input logic [4:0] rd,
                               input logic rw, input logic ld,
                               input logic [63:0] rf1, input logic [63:0] rf2);
    vec_t x;
    x = '{vld: vld, rn: rn, rm: rm, urn: urn, urm: urm, rd: rd, rw: rw, ld: ld,
          imm: 64'd0, ctrl: 16'd0, rf1: rf1, rf2: rf2, exres: 64'd0, mrw: 1'b0,
          mrd: 5'd0, mdata: 64'd0, wrw: 1'b0, wrd: 5'd0, wdata: 64'd0, fl: 1'b0,
          e_stall: 1'b0, e_v: 1'b0, e_a: 64'd0, e_b: 64'd0, e_rd: 5'd0, e_cnt: 16'd0};
    return x;
  endfunction

  function automatic vec_t expect_set(input vec_t x, input logic st, input logic v,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [4:0] rd, input logic [15:0] cnt);
    vec_t y;
    y = x;
    y.e_stall = st; y.e_v = v; y.e_a = a; y.e_b = b; y.e_rd = rd; y.e_cnt = cnt;
    return y;
  endfunction

  task automatic drive(input vec_t x);
    id_valid = x.vld; id_rn = x.rn; id_rm = x.rm; id_uses_rn = x.urn; id_uses_rm = x.urm;
    id_rd = x.rd; id_reg_write = x.rw; id_is_load = x.ld; id_imm = x.imm; id_ctrl = x.ctrl;
    rf_data1 = x.rf1; rf_data2 = x.rf2; ex_alu_result = x.exres;
    mem_reg_write = x.mrw; mem_rd = x.mrd; mem_data = x.mdata;
    wb_reg_write = x.wrw; wb_rd = x.wrd; wb_data = x.wdata; flush = x.fl;
  endtask

  // Reference operand resolution: XZR reads zero; else first matching writer in EX, MEM, WB order.
  function automatic logic [63:0] ref_op(input logic [4:0] src, input logic uses,
                                         input logic [63:0] rfv, input logic ex_we,
                                         input logic [4:0] ex_dst, input vec_t x);
    logic        we[3];
    logic [4:0]  dst[3];
    logic [63:0] val[3];
    if (src == 5'd31) return 64'd0;
    we[0] = ex_we;  dst[0] = ex_dst; val[0] = x.exres;
    we[1] = x.mrw;  dst[1] = x.mrd;  val[1] = x.mdata;
    we[2] = x.wrw;  dst[2] = x.wrd;  val[2] = x.wdata;
    for (int k = 0; k < 3; k++)
      if (uses && we[k] && dst[k] == src) return val[k];
    return rfv;
  endfunction

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 9);
    return (r >= 8) ? 5'd31 : 5'(r);
  endfunction

  vec_t tbl[13];
  vec_t rv;

  // Reference-model state mirroring the ID/EX register contents.
  logic        m_v, m_rw, m_ld, lu, e_st, cap;
  logic [4:0]  m_rd;
  logic [63:0] m_a, m_b, m_imm, na, nb;
  logic [15:0] m_ctrl;
  int          m_cnt;

  initial begin
    s_rst_n = 1'b0;
    reset_n = 1'b0;
    drive(ins(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 64'd0, 64'd0));

    tbl[0]  = expect_set(ins(1,1,2,1,1,3,1,0,64'd5,64'd7), 0,1,64'd5,64'd7,5'd3,16'd0);
    tbl[1]  = expect_set(ins(1,0,0,1,1,1,1,0,64'd0,64'd0), 0,1,64'd0,64'd0,5'd1,16'd0);
    tbl[2]  = expect_set(ins(1,1,1,1,1,4,1,0,64'h99,64'h99), 0,1,64'h10,64'h10,5'd4,16'd0);
    tbl[2].exres = 64'h10; tbl[2].mrw = 1; tbl[2].mrd = 1; tbl[2].mdata = 64'h20;
    tbl[2].wrw = 1; tbl[2].wrd = 1; tbl[2].wdata = 64'h30;
    tbl[3]  = expect_set(ins(1,9,31,1,1,10,0,0,64'h1111,64'h2222), 0,1,64'hABCD,64'd0,5'd10,16'd0);
    tbl[3].exres = 64'h5; tbl[3].mrw = 1; tbl[3].mrd = 31; tbl[3].mdata = 64'h77;
    tbl[3].wrw = 1; tbl[3].wrd = 9; tbl[3].wdata = 64'hABCD;
    tbl[4]  = expect_set(ins(1,7,8,1,1,11,1,0,64'h70,64'h88), 0,1,64'h20,64'h88,5'd11,16'd0);
    tbl[4].exres = 64'h7; tbl[4].mrw = 1; tbl[4].mrd = 7; tbl[4].mdata = 64'h20;
    tbl[4].wrw = 1; tbl[4].wrd = 7; tbl[4].wdata = 64'h30;
    tbl[5]  = expect_set(ins(1,2,11,1,0,5,1,1,64'h100,64'h5), 0,1,64'h100,64'h5,5'd5,16'd0);
    tbl[5].exres = 64'h3;
    tbl[6]  = expect_set(ins(1,5,2,1,1,6,1,0,64'h9,64'h2), 1,0,64'd0,64'd0,5'd0,16'd1);
    tbl[7]  = expect_set(ins(1,5,2,1,1,6,1,0,64'h9,64'h2), 0,1,64'h55,64'h2,5'd6,16'd1);
    tbl[7].mrw = 1; tbl[7].mrd = 5; tbl[7].mdata = 64'h55;
    tbl[8]  = expect_set(ins(1,0,0,1,0,5,1,1,64'd0,64'd0), 0,1,64'd0,64'd0,5'd5,16'd1);
    tbl[9]  = expect_set(ins(1,5,2,1,1,6,1,0,64'h9,64'h2), 0,0,64'd0,64'd0,5'd0,16'd1);
    tbl[9].fl = 1;
    tbl[10] = expect_set(ins(0,5,2,1,1,6,1,0,64'h9,64'h2), 0,0,64'd0,64'd0,5'd0,16'd1);
    tbl[11] = expect_set(ins(1,0,0,1,0,31,1,1,64'd0,64'd0), 0,1,64'd0,64'd0,5'd31,16'd1);
    tbl[12] = expect_set(ins(1,31,3,1,1,7,1,0,64'h5,64'h3), 0,1,64'd0,64'h3,5'd7,16'd1);
    tbl[12].exres = 64'h44;

    // Reset held two cycles with a valid instruction presented.
    repeat (2) begin
      @(negedge clk);
      chk("reset_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
    chk("reset_valid", 64'(ex_valid), 64'd0);
    chk("reset_op_a", ex_op_a, 64'd0);
    chk("reset_count", 64'(stall_count), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(tbl[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 64'(ex_valid), 64'(tbl[i].e_v));
      chk($sformatf("vec%0d_op_a", i), ex_op_a, tbl[i].e_a);
      chk($sformatf("vec%0d_op_b", i), ex_op_b, tbl[i].e_b);
      chk($sformatf("vec%0d_rd", i), 64'(ex_rd), 64'(tbl[i].e_rd));
      chk($sformatf("vec%0d_count", i), 64'(stall_count), 64'(tbl[i].e_cnt));
    end

    // Randomized run against the reference model, starting from reset.
    reset_n = 1'b0;
    @(posedge clk); #1;
    m_v = 0; m_rw = 0; m_ld = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      rv = ins($urandom_range(0, 3) != 0, rnd_reg(), rnd_reg(), 1'($urandom),
               1'($urandom), rnd_reg(), 1'($urandom), $urandom_range(0, 2) == 0,
               {$urandom, $urandom}, {$urandom, $urandom});
      rv.imm = {$urandom, $urandom}; rv.ctrl = 16'($urandom);
      rv.exres = {$urandom, $urandom};
      rv.mrw = 1'($urandom); rv.mrd = rnd_reg(); rv.mdata = {$urandom, $urandom};
      rv.wrw = 1'($urandom); rv.wrd = rnd_reg(); rv.wdata = {$urandom, $urandom};
      rv.fl = ($urandom_range(0, 9) == 0);
      reset_n = ($urandom_range(0, 49) != 0);
      drive(rv);

      lu = rv.vld && m_v && m_ld && m_rd != 5'd31 &&
           ((rv.urn && rv.rn == m_rd) || (rv.urm && rv.rm == m_rd));
      e_st = reset_n && !rv.fl && lu;
      cap  = !rv.fl && !lu && rv.vld;
      na = ref_op(rv.rn, rv.urn, rv.rf1, m_v && m_rw && !m_ld, m_rd, rv);
      nb = ref_op(rv.rm, rv.urm, rv.rf2, m_v && m_rw && !m_ld, m_rd, rv);

      @(negedge clk);
      chk("rnd_stall", 64'(stall), 64'(e_st));
      @(posedge clk); #1;

      if (!reset_n) begin
        m_v = 0; m_rw = 0; m_ld = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0;
        m_cnt = 0;
      end else begin
        if (e_st && m_cnt < 65535) m_cnt++;
        m_v = cap; m_rw = cap && rv.rw; m_ld = cap && rv.ld;
        m_rd = cap ? rv.rd : 5'd0; m_a = cap ? na : 64'd0; m_b = cap ? nb : 64'd0;
        m_imm = cap ? rv.imm : 64'd0; m_ctrl = cap ? rv.ctrl : 16'd0;
      end
      chk("rnd_valid", 64'(ex_valid), 64'(m_v));
      chk("rnd_reg_write", 64'(ex_reg_write), 64'(m_rw));
      chk("rnd_is_load", 64'(ex_is_load), 64'(m_ld));
      chk("rnd_rd", 64'(ex_rd), 64'(m_rd));
      chk("rnd_op_a", ex_op_a, m_a);
      chk("rnd_op_b", ex_op_b, m_b);
      chk("rnd_imm", ex_imm, m_imm);
      chk("rnd_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
      chk("rnd_count", 64'(stall_count), 64'(m_cnt));
    end

    // Saturation: a stall every second edge; a 4-bit counter must stop at 15.
    reset_n = 1'b1;
    s_rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("sat_count_10", 64'(s_cnt), 64'd5);
    repeat (30) @(posedge clk);
    #1;
    chk("sat_count_40", 64'(s_cnt), 64'd15);
    repeat (20) @(posedge clk);
    #1;
    chk("sat_count_60", 64'(s_cnt), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
